// File: rtl/seven_segment_scanner.sv
// Four-digit common-anode 7-segment scanner for the irrigation controller status.
// Status is snapshotted once per frame; every pin is registered and idles high (dark).
module seven_segment_scanner #(
    parameter int REFRESH_DIV  = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] encoded_water,
    input  logic       splinker_mode_on,
    input  logic       irrigation_on,
    input  logic       water_supply_valvule,
    input  logic       alarm,
    input  logic       conflicting_values,
    output logic       segment_a,
    output logic       segment_b,
    output logic       segment_c,
    output logic       segment_d,
    output logic       segment_e,
    output logic       segment_f,
    output logic       segment_g,
    output logic       display_0,
    output logic       display_1,
    output logic       display_2,
    output logic       display_3,
    output logic       displays_point
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Glyphs are active-high gfedcba; the pins carry the inverse.
    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_S     = 7'b1101101;
    localparam logic [6:0] GLYPH_D     = 7'b1011110;
    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    typedef struct packed {
        logic [1:0] water;
        logic       sprinkler;
        logic       irrigation;
        logic       valve;
        logic       alarm;
        logic       conflict;
    } status_t;

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [1:0]    slot_q, slot_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;
    status_t       snapshot_q, snapshot_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    disp_q, disp_d;
    logic          point_q, point_d;

    logic          tick;
    logic          frame_end;
    status_t       live;
    logic [6:0]    glyph;

    assign live = '{water:      encoded_water,
                    sprinkler:  splinker_mode_on,
                    irrigation: irrigation_on,
                    valve:      water_supply_valvule,
                    alarm:      alarm,
                    conflict:   conflicting_values};

    always_comb begin
        assert (REFRESH_DIV >= 2 && BLINK_FRAMES >= 1)
            else $error("seven_segment_scanner: REFRESH_DIV must be >= 2 and BLINK_FRAMES >= 1");

        tick        = (prescaler_q == PRESC_LAST);
        frame_end   = tick && (slot_q == 2'd3);
        prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        slot_d      = tick ? slot_q + 2'd1 : slot_q;
        snapshot_d  = frame_end ? live : snapshot_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_end) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    // Decode is driven by the current state, so the pins land one cycle behind it.
    always_comb begin
        glyph = GLYPH_BLANK;
        unique case (slot_q)
            2'd3: begin
                unique case (snapshot_q.water)
                    2'b00:   glyph = GLYPH_0;
                    2'b01:   glyph = GLYPH_1;
                    2'b10:   glyph = GLYPH_2;
                    default: glyph = GLYPH_3;
                endcase
            end
            2'd2: begin
                if (!snapshot_q.irrigation) glyph = GLYPH_DASH;
                else if (snapshot_q.sprinkler) glyph = GLYPH_S;
                else glyph = GLYPH_D;
            end
            2'd1: glyph = snapshot_q.valve ? GLYPH_A : GLYPH_BLANK;
            default: begin
                if (snapshot_q.conflict) glyph = blink_q ? GLYPH_E : GLYPH_BLANK;
                else if (snapshot_q.alarm) glyph = GLYPH_A;
                else glyph = GLYPH_BLANK;
            end
        endcase

        seg_d   = ~glyph;
        point_d = ~((slot_q == 2'd2) && snapshot_q.irrigation);

        disp_d = 4'b1111;
        if (prescaler_q != '0) begin
            unique case (slot_q)
                2'd0:    disp_d = 4'b1110;
                2'd1:    disp_d = 4'b1101;
                2'd2:    disp_d = 4'b1011;
                default: disp_d = 4'b0111;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q <= '0;
            slot_q      <= '0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
            snapshot_q  <= '0;
            seg_q       <= '1;
            disp_q      <= '1;
            point_q     <= 1'b1;
        end else begin
            prescaler_q <= prescaler_d;
            slot_q      <= slot_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            snapshot_q  <= snapshot_d;
            seg_q       <= seg_d;
            disp_q      <= disp_d;
            point_q     <= point_d;
        end
    end

    assign segment_a      = seg_q[0];
    assign segment_b      = seg_q[1];
    assign segment_c      = seg_q[2];
    assign segment_d      = seg_q[3];
    assign segment_e      = seg_q[4];
    assign segment_f      = seg_q[5];
    assign segment_g      = seg_q[6];
    assign display_0      = disp_q[0];
    assign display_1      = disp_q[1];
    assign display_2      = disp_q[2];
    assign display_3      = disp_q[3];
    assign displays_point = point_q;

endmodule
